// File: rtl/msh_bank_pkg.sv
// msh_bank_pkg: shared widths and scheduler state encoding
// for the mesh bank request scheduler.
package msh_bank_pkg;

  localparam int MSH_BANK_ADR_W  = 12;
  localparam int MSH_BANK_DATA_W = 552;
  localparam int MSH_BANK_TAG_W  = 8;
  localparam int MSH_BANK_RSP_W  = MSH_BANK_DATA_W + MSH_BANK_TAG_W + 1;

  typedef enum logic [1:0] {
    INIT,
    ACTIVE,
    SLEEP,
    WAKE
  } msh_bank_state_e;

endpackage

// File: rtl/msh_bank_sync_fifo.sv
// msh_bank_sync_fifo: single-clock FIFO with occupancy count.
// A push into a full FIFO is taken only when a pop frees a slot.
module msh_bank_sync_fifo
  import msh_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/msh_bank_req_sched.sv
// msh_bank_req_sched: request scheduler, read credit control and
// in-order responses for one bank; light sleep via MBY_MSH_BANK_LS_EN.
module msh_bank_req_sched
  import msh_bank_pkg::*;
#(
  parameter int IDLE_CYCLES = 64,
  parameter int WAKE_CYCLES = 2,
  parameter int RSP_DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_wr,
  input  logic [MSH_BANK_ADR_W-1:0]  req_adr,
  input  logic [MSH_BANK_DATA_W-1:0] req_wr_data,
  input  logic [MSH_BANK_TAG_W-1:0]  req_tag,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [MSH_BANK_DATA_W-1:0] rsp_data,
  output logic [MSH_BANK_TAG_W-1:0]  rsp_tag,
  output logic                       rsp_err,
  output logic [MSH_BANK_ADR_W-1:0]  bank_adr,
  output logic                       bank_rd_en,
  output logic                       bank_wr_en,
  output logic [MSH_BANK_DATA_W-1:0] bank_wr_data,
  output logic                       bank_mem_ls_enter,
  input  logic [MSH_BANK_DATA_W-1:0] bank_rd_data,
  input  logic                       bank_rd_valid,
  input  logic                       bank_ecc_uncor_err,
  input  logic                       bank_init_done,
  output logic                       protocol_err
);

  localparam int CW = $clog2(RSP_DEPTH + 1);

  if (IDLE_CYCLES < 1 || WAKE_CYCLES < 1 || RSP_DEPTH < 1) begin : g_bad_cfg
    $error("msh_bank_req_sched: cycle counts and depth must be >= 1");
  end

  msh_bank_state_e state;
  msh_bank_state_e state_nxt;

  logic [CW-1:0]             tag_cnt;
  logic [CW-1:0]             rsp_cnt;
  logic [CW:0]               credits_used;
  logic                      tag_empty;
  logic                      rsp_empty;
  logic [MSH_BANK_TAG_W-1:0] tag_head;
  logic [MSH_BANK_RSP_W-1:0] rsp_head;
  logic                      accept;
  logic                      rd_accept;
  logic                      rsp_push;
  logic                      rsp_pop;
  logic                      rd_en_q;
  logic                      wr_en_q;
  logic                      perr_q;

  // Accepted reads hold a credit until their response is popped.
  assign credits_used = {1'b0, tag_cnt} + {1'b0, rsp_cnt};

  assign req_ready = !reset && (state == ACTIVE) &&
                     (req_wr || credits_used < (CW+1)'(RSP_DEPTH));
  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && !req_wr;

  assign rsp_push  = bank_rd_valid && !tag_empty;
  assign rsp_valid = !reset && !rsp_empty;
  assign rsp_pop   = rsp_valid && rsp_ready;

  assign {rsp_data, rsp_tag, rsp_err} = rsp_valid ? rsp_head : '0;

  assign bank_rd_en   = rd_en_q && !reset;
  assign bank_wr_en   = wr_en_q && !reset;
  assign protocol_err = perr_q && !reset;

  msh_bank_sync_fifo #(
    .WIDTH(MSH_BANK_TAG_W),
    .DEPTH(RSP_DEPTH)
  ) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (rd_accept),
    .push_data(req_tag),
    .pop      (bank_rd_valid),
    .head     (tag_head),
    .count    (tag_cnt),
    .empty    (tag_empty)
  );

  msh_bank_sync_fifo #(
    .WIDTH(MSH_BANK_RSP_W),
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (rsp_push),
    .push_data({bank_rd_data, tag_head, bank_ecc_uncor_err}),
    .pop      (rsp_pop),
    .head     (rsp_head),
    .count    (rsp_cnt),
    .empty    (rsp_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      bank_adr     <= '0;
      bank_wr_data <= '0;
      perr_q       <= 1'b0;
    end else begin
      rd_en_q      <= rd_accept;
      wr_en_q      <= accept && req_wr;
      bank_adr     <= accept ? req_adr : '0;
      bank_wr_data <= (accept && req_wr) ? req_wr_data : '0;
      if (bank_rd_valid && tag_empty) perr_q <= 1'b1;
    end
  end

`ifdef MBY_MSH_BANK_LS_EN
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int WW = $clog2(WAKE_CYCLES + 1);

  logic [IW-1:0] idle_cnt;
  logic [WW-1:0] wake_cnt;
  logic          idle;
  logic          idle_done;
  logic          wake_done;

  assign idle = (state == ACTIVE) && !accept && tag_empty && rsp_empty &&
                !rd_en_q && !wr_en_q && !bank_rd_valid;
  // Sleep is entered right after the IDLE_CYCLES-th idle cycle.
  assign idle_done = idle && (idle_cnt >= IW'(IDLE_CYCLES - 1));
  assign wake_done = (wake_cnt >= WW'(WAKE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt <= '0;
      wake_cnt <= '0;
    end else begin
      if (!idle)                            idle_cnt <= '0;
      else if (idle_cnt != IW'(IDLE_CYCLES)) idle_cnt <= idle_cnt + IW'(1);
      wake_cnt <= (state == WAKE) ? wake_cnt + WW'(1) : '0;
    end
  end

  assign bank_mem_ls_enter = !reset && (state == SLEEP);
`else
  assign bank_mem_ls_enter = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT:   if (bank_init_done) state_nxt = ACTIVE;
`ifdef MBY_MSH_BANK_LS_EN
      ACTIVE: if (idle_done) state_nxt = SLEEP;
      SLEEP:  if (req_valid) state_nxt = WAKE;
      WAKE:   if (wake_done) state_nxt = ACTIVE;
`else
      ACTIVE: state_nxt = ACTIVE;
      SLEEP,
      WAKE:   state_nxt = INIT;
`endif
    endcase
    // Losing init_done sends the block back to INIT; FIFOs keep their contents.
    if (state != INIT && !bank_init_done) state_nxt = INIT;
  end

endmodule

// File: tb/tb_msh_bank_req_sched.sv
// tb_msh_bank_req_sched: directed scenarios plus random traffic against
// a queue-based reference model and a behavioural bank responder.
module tb_msh_bank_req_sched;
  import msh_bank_pkg::*;

  localparam int DEPTH  = 4;
  localparam int IDLE_N = 64;
  localparam int WAKE_N = 2;
`ifdef MBY_MSH_BANK_LS_EN
  localparam int LS_ON = 1;
`else
  localparam int LS_ON = 0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic         req_wr;
  logic [11:0]  req_adr;
  logic [551:0] req_wr_data;
  logic [7:0]   req_tag;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [551:0] rsp_data;
  logic [7:0]   rsp_tag;
  logic         rsp_err;
  logic [11:0]  bank_adr;
  logic         bank_rd_en;
  logic         bank_wr_en;
  logic [551:0] bank_wr_data;
  logic         bank_mem_ls_enter;
  logic [551:0] bank_rd_data;
  logic         bank_rd_valid;
  logic         bank_ecc_uncor_err;
  logic         bank_init_done;
  logic         protocol_err;

  always #5 clk = ~clk;

  msh_bank_req_sched dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_wr            (req_wr),
    .req_adr           (req_adr),
    .req_wr_data       (req_wr_data),
    .req_tag           (req_tag),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_data          (rsp_data),
    .rsp_tag           (rsp_tag),
    .rsp_err           (rsp_err),
    .bank_adr          (bank_adr),
    .bank_rd_en        (bank_rd_en),
    .bank_wr_en        (bank_wr_en),
    .bank_wr_data      (bank_wr_data),
    .bank_mem_ls_enter (bank_mem_ls_enter),
    .bank_rd_data      (bank_rd_data),
    .bank_rd_valid     (bank_rd_valid),
    .bank_ecc_uncor_err(bank_ecc_uncor_err),
    .bank_init_done    (bank_init_done),
    .protocol_err      (protocol_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [599:0] got,
                       input logic [599:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [551:0] d;
    logic [7:0]   t;
    logic         e;
  } rsp_t;

  logic [7:0]   tag_q[$];
  rsp_t         rsp_q[$];
  bit           m_active;
  bit           m_perr;
  bit           m_rd;
  bit           m_wr;
  logic [11:0]  m_adr;
  logic [551:0] m_wdata;
  int           m_idle;
  int           m_wake;
  bit           m_sleep;
  int           bank_pend;
  bit           bank_auto;
  int           n_acc;

  function automatic logic [551:0] rnd_data();
    logic [551:0] v;
    for (int i = 0; i < 17; i++) v[i*32 +: 32] = $urandom;
    v[551:544] = 8'($urandom);
    return v;
  endfunction

  // One cycle: called at a falling edge with inputs set, returns at the next.
  task automatic tick();
    bit   exp_ready;
    bit   exp_rv;
    bit   acc;
    bit   idle;
    rsp_t hd;
    rsp_t nr;
    if (bank_auto) begin
      bank_rd_valid      = (bank_pend > 0) && ($urandom_range(0, 2) != 0);
      bank_rd_data       = rnd_data();
      bank_ecc_uncor_err = ($urandom_range(0, 7) == 0);
    end
    #1;
    exp_ready = !reset && m_active && !m_sleep && (m_wake == 0) &&
                (req_wr || (tag_q.size() + rsp_q.size()) < DEPTH);
    exp_rv = !reset && (rsp_q.size() > 0);
    if (exp_rv) hd = rsp_q[0];
    else        hd = '{d: '0, t: '0, e: 1'b0};
    check("req_ready", req_ready, exp_ready);
    check("rsp_valid", rsp_valid, exp_rv);
    check("rsp_data", rsp_data, hd.d);
    check("rsp_tag", rsp_tag, hd.t);
    check("rsp_err", rsp_err, hd.e);
    check("bank_rd_en", bank_rd_en, m_rd && !reset);
    check("bank_wr_en", bank_wr_en, m_wr && !reset);
    check("bank_adr", bank_adr, m_adr);
    check("bank_wr_data", bank_wr_data, m_wdata);
    check("ls_enter", bank_mem_ls_enter, m_sleep && !reset);
    check("protocol_err", protocol_err, m_perr && !reset);
    if (reset) begin
      tag_q.delete();
      rsp_q.delete();
      m_active  = 0;
      m_perr    = 0;
      m_rd      = 0;
      m_wr      = 0;
      m_adr     = '0;
      m_wdata   = '0;
      m_idle    = 0;
      m_wake    = 0;
      m_sleep   = 0;
      bank_pend = 0;
    end else begin
      acc = req_valid && exp_ready;
      if (acc) n_acc++;
      idle = m_active && !m_sleep && (m_wake == 0) && !acc &&
             (tag_q.size() == 0) && (rsp_q.size() == 0) &&
             !m_rd && !m_wr && !bank_rd_valid;
      if (exp_rv && rsp_ready) void'(rsp_q.pop_front());
      if (bank_rd_valid) begin
        if (tag_q.size() > 0) begin
          nr.d = bank_rd_data;
          nr.t = tag_q.pop_front();
          nr.e = bank_ecc_uncor_err;
          rsp_q.push_back(nr);
        end else begin
          m_perr = 1;
        end
        if (bank_pend > 0) bank_pend--;
      end
      if (bank_rd_en) bank_pend++;
      if (acc && !req_wr) tag_q.push_back(req_tag);
      m_rd    = acc && !req_wr;
      m_wr    = acc && req_wr;
      m_adr   = acc ? req_adr : '0;
      m_wdata = (acc && req_wr) ? req_wr_data : '0;
      if (!bank_init_done) begin
        m_active = 0;
        m_sleep  = 0;
        m_wake   = 0;
        m_idle   = 0;
      end else if (!m_active) begin
        m_active = 1;
      end else if (m_sleep) begin
        if (req_valid) begin
          m_sleep = 0;
          m_wake  = WAKE_N;
        end
      end else if (m_wake > 0) begin
        m_wake--;
      end else begin
        m_idle = idle ? m_idle + 1 : 0;
        if (LS_ON != 0 && m_idle == IDLE_N) begin
          m_sleep = 1;
          m_idle  = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (tag_q.size() + rsp_q.size()) > 0; i++) tick();
    check("drain_timeout", tag_q.size() + rsp_q.size(), 0);
  endtask

  initial begin
    logic [551:0] dval;
    reset = 1; req_valid = 0; req_wr = 0; req_adr = '0;
    req_wr_data = '0; req_tag = '0; rsp_ready = 1;
    bank_rd_valid = 0; bank_rd_data = '0; bank_ecc_uncor_err = 0;
    bank_init_done = 0; bank_auto = 1;
    m_active = 0; m_perr = 0; m_rd = 0; m_wr = 0; m_adr = '0;
    m_wdata = '0; m_idle = 0; m_wake = 0; m_sleep = 0;
    bank_pend = 0; n_acc = 0;
    @(negedge clk);
    repeat (2) tick();
    reset = 0;

    // init gating
    req_valid = 1; req_wr = 0; req_adr = 12'h001; req_tag = 8'h01;
    repeat (10) tick();
    bank_init_done = 1;
    n_acc = 0;
    tick();
    check("init_no_xfer", n_acc, 0);
    tick();
    check("init_first_xfer", n_acc, 1);
    req_valid = 0;
    drain();

    // write then read at one address, bank flags uncorrectable ECC
    bank_auto = 0; bank_rd_valid = 0; n_acc = 0;
    req_valid = 1; req_wr = 1; req_adr = 12'h123; req_wr_data = rnd_data();
    tick();
    req_wr = 0; req_tag = 8'h5A;
    tick();
    req_valid = 0;
    tick();
    dval = rnd_data();
    bank_rd_valid = 1; bank_rd_data = dval; bank_ecc_uncor_err = 1;
    tick();
    bank_rd_valid = 0; bank_ecc_uncor_err = 0;
    check("wr_rd_rsp_data", rsp_data, dval);
    check("wr_rd_rsp_tag", rsp_tag, 8'h5A);
    check("wr_rd_rsp_err", rsp_err, 1'b1);
    tick();
    check("wr_rd_accepts", n_acc, 2);

    // credit backpressure
    bank_auto = 1; rsp_ready = 0; n_acc = 0;
    req_valid = 1; req_wr = 0;
    for (int i = 0; i < 20; i++) begin
      req_tag = 8'(8'h10 + n_acc);
      req_adr = 12'($urandom);
      tick();
    end
    check("credit_accepts", n_acc, 4);
    rsp_ready = 1;
    tick();
    check("credit_pop_cycle", n_acc, 4);
    tick();
    check("credit_after_pop", n_acc, 5);
    req_valid = 0;
    drain();

    // idle run, then a request
    repeat (IDLE_N + 6) tick();
    check("idle_ls_enter", bank_mem_ls_enter, LS_ON);
    n_acc = 0;
    req_valid = 1; req_wr = 1; req_adr = 12'h3C5; req_wr_data = rnd_data();
    repeat (4) tick();
    check("wake_accepts", n_acc, (LS_ON != 0) ? 1 : 4);
    req_valid = 0;
    drain();
    repeat (3) tick();

    // read data with nothing outstanding
    bank_auto = 0;
    bank_rd_valid = 1; bank_rd_data = rnd_data();
    tick();
    bank_rd_valid = 0;
    repeat (5) tick();
    check("perr_sticky", protocol_err, 1'b1);
    check("perr_no_rsp", rsp_valid, 1'b0);

    // reset with three reads outstanding
    reset = 1;
    tick();
    reset = 0;
    repeat (2) tick();
    n_acc = 0; req_valid = 1; req_wr = 0;
    for (int i = 0; i < 10 && n_acc < 3; i++) begin
      req_tag = 8'(8'hA0 + n_acc);
      tick();
    end
    req_valid = 0;
    check("mid_rst_issued", n_acc, 3);
    tick();
    reset = 1;
    tick();
    reset = 0;
    bank_rd_valid = 1; bank_rd_data = rnd_data();
    tick();
    bank_rd_valid = 0;
    repeat (5) tick();
    check("mid_rst_no_rsp", rsp_valid, 1'b0);
    check("mid_rst_dropped", protocol_err, 1'b1);

    // random traffic
    reset = 1;
    tick();
    reset = 0; bank_auto = 1;
    for (int i = 0; i < 3000; i++) begin
      bank_init_done = ($urandom_range(0, 63) != 0);
      req_valid   = 1'($urandom_range(0, 1));
      req_wr      = 1'($urandom_range(0, 1));
      req_adr     = 12'($urandom);
      req_wr_data = rnd_data();
      req_tag     = 8'($urandom);
      rsp_ready   = ($urandom_range(0, 3) != 0);
      reset       = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 0; req_valid = 0; rsp_ready = 1; bank_init_done = 1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
